mem_arbiter: RTL and testbench

- Shares a single unified memory port between the fetch instruction request and the LSU data-bus request.
- Sits between pipeline_top's instruction-memory and data-bus outputs and one memory/bus slave.
- Only one transaction is outstanding at a time.
- LSU has priority. A streak counter bounds fetch starvation.
- Requesters can withdraw: flush for LSU, kill for fetch redirect. Their acks are then suppressed.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_if.sv | 50 +++++
 rtl/mem_arb_wdt.sv | 28 ++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared state encoding, grant-owner codes and default sizing for the
// fetch/LSU unified memory port arbiter.
package mem_arb_pkg;

    localparam logic [1:0] MEM_ARB_OWN_NONE = 2'd0;
    localparam logic [1:0] MEM_ARB_OWN_IF   = 2'd1;
    localparam logic [1:0] MEM_ARB_OWN_LSU  = 2'd2;

    localparam int MEM_ARB_DEF_XLEN    = 32;
    localparam int MEM_ARB_DEF_STREAK  = 4;
    localparam int MEM_ARB_DEF_TIMEOUT = 255;

    // A busy state's encoding is the owner code of the requester it serves.
    typedef enum logic [1:0] {
        MEM_ARB_IDLE     = MEM_ARB_OWN_NONE,
        MEM_ARB_IF_BUSY  = MEM_ARB_OWN_IF,
        MEM_ARB_LSU_BUSY = MEM_ARB_OWN_LSU
    } type_mem_arb_state_e;

endpackage

// File: rtl/mem_arb_if.sv
// Requester and memory-slave signals of the arbiter; master = arbiter view,
// slave = the surrounding pipeline/memory view.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int XLEN = MEM_ARB_DEF_XLEN
);
    logic              if_req_i;
    logic [XLEN-1:0]   if_addr_i;
    logic              if_kill_i;
    logic              if_ack_o;
    logic [XLEN-1:0]   if_rdata_o;

    logic              lsu_req_i;
    logic [XLEN-1:0]   lsu_addr_i;
    logic [XLEN-1:0]   lsu_wdata_i;
    logic [XLEN/8-1:0] lsu_sel_i;
    logic              lsu_w_en_i;
    logic              lsu_flush_i;
    logic              lsu_ack_o;
    logic [XLEN-1:0]   lsu_rdata_o;

    logic              mem_req_o;
    logic [XLEN-1:0]   mem_addr_o;
    logic [XLEN-1:0]   mem_wdata_o;
    logic [XLEN/8-1:0] mem_sel_o;
    logic              mem_w_en_o;
    logic              mem_ack_i;
    logic [XLEN-1:0]   mem_rdata_i;
    logic              mem_err_o;

    modport master (
        input  if_req_i, if_addr_i, if_kill_i,
        output if_ack_o, if_rdata_o,
        input  lsu_req_i, lsu_addr_i, lsu_wdata_i, lsu_sel_i, lsu_w_en_i, lsu_flush_i,
        output lsu_ack_o, lsu_rdata_o,
        output mem_req_o, mem_addr_o, mem_wdata_o, mem_sel_o, mem_w_en_o, mem_err_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        output if_req_i, if_addr_i, if_kill_i,
        input  if_ack_o, if_rdata_o,
        output lsu_req_i, lsu_addr_i, lsu_wdata_i, lsu_sel_i, lsu_w_en_i, lsu_flush_i,
        input  lsu_ack_o, lsu_rdata_o,
        input  mem_req_o, mem_addr_o, mem_wdata_o, mem_sel_o, mem_w_en_o, mem_err_o,
        output mem_ack_i, mem_rdata_i
    );

endinterface

// File: rtl/mem_arb_wdt.sv
// Busy-cycle watchdog for the memory arbiter; flags the BUSY cycle in which
// TIMEOUT_CYCLES have elapsed since the grant.
module mem_arb_wdt
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = MEM_ARB_DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic busy,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (busy && cnt != CW'(TIMEOUT_CYCLES))
            cnt <= cnt + 1'b1;
    end

    // cnt holds the number of BUSY cycles already elapsed before this one.
    assign expired = busy && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/LSU arbiter onto a single memory port, one transaction in flight.
// Optional watchdog abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN           = MEM_ARB_DEF_XLEN,
    parameter int MAX_LSU_STREAK = MEM_ARB_DEF_STREAK,
    parameter int TIMEOUT_CYCLES = MEM_ARB_DEF_TIMEOUT
) (
    input  logic     clk,
    input  logic     rst,
    mem_arb_if.master bus
);
    localparam int SW = $clog2(MAX_LSU_STREAK + 1);
    localparam int BW = XLEN / 8;

    type_mem_arb_state_e state;
    logic [SW-1:0]       streak;
    logic                drop;

    logic                req_q;
    logic [XLEN-1:0]     addr_q;
    logic [XLEN-1:0]     wdata_q;
    logic [BW-1:0]       sel_q;
    logic                w_en_q;

    logic fetch_ok, lsu_ok, force_if, grant_lsu, grant_if;
    logic busy, timeout, done;

    assign fetch_ok  = bus.if_req_i & ~bus.if_kill_i;
    assign lsu_ok    = bus.lsu_req_i & ~bus.lsu_flush_i;
    assign force_if  = fetch_ok && (streak == SW'(MAX_LSU_STREAK));
    assign grant_lsu = (state == MEM_ARB_IDLE) && lsu_ok && !force_if;
    assign grant_if  = (state == MEM_ARB_IDLE) && !grant_lsu && fetch_ok;
    assign busy      = (state != MEM_ARB_IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
    logic wdt_expired;

    mem_arb_wdt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdt (
        .clk     (clk),
        .rst     (rst),
        .clr     (grant_lsu | grant_if),
        .busy    (busy),
        .expired (wdt_expired)
    );

    // A real ack in the expiry cycle wins over the abort.
    assign timeout = busy & wdt_expired & ~bus.mem_ack_i;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout            = 1'b0;
`endif

    assign done = busy & (bus.mem_ack_i | timeout);

    assign bus.if_ack_o    = done & (state == MEM_ARB_IF_BUSY)  & ~drop;
    assign bus.lsu_ack_o   = done & (state == MEM_ARB_LSU_BUSY) & ~drop;
    assign bus.if_rdata_o  = timeout ? '0 : bus.mem_rdata_i;
    assign bus.lsu_rdata_o = timeout ? '0 : bus.mem_rdata_i;
    assign bus.mem_err_o   = timeout;

    assign bus.mem_req_o   = req_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.mem_sel_o   = sel_q;
    assign bus.mem_w_en_o  = w_en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= MEM_ARB_IDLE;
            streak  <= '0;
            drop    <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            w_en_q  <= 1'b0;
        end else begin
            case (state)
                MEM_ARB_IDLE: begin
                    drop <= 1'b0;
                    if (grant_lsu) begin
                        state   <= MEM_ARB_LSU_BUSY;
                        req_q   <= 1'b1;
                        addr_q  <= bus.lsu_addr_i;
                        wdata_q <= bus.lsu_wdata_i;
                        sel_q   <= bus.lsu_sel_i;
                        w_en_q  <= bus.lsu_w_en_i;
                        // Streak only grows while fetch is waiting behind the LSU.
                        if (!bus.if_req_i)
                            streak <= '0;
                        else if (streak != SW'(MAX_LSU_STREAK))
                            streak <= streak + 1'b1;
                    end else if (grant_if) begin
                        state   <= MEM_ARB_IF_BUSY;
                        req_q   <= 1'b1;
                        addr_q  <= bus.if_addr_i;
                        wdata_q <= '0;
                        sel_q   <= '1;
                        w_en_q  <= 1'b0;
                        streak  <= '0;
                    end else if (!bus.if_req_i) begin
                        streak <= '0;
                    end
                end
                default: begin
                    if (done) begin
                        state <= MEM_ARB_IDLE;
                        req_q <= 1'b0;
                        drop  <= 1'b0;
                    end else if ((state == MEM_ARB_LSU_BUSY && bus.lsu_flush_i) ||
                                 (state == MEM_ARB_IF_BUSY  && bus.if_kill_i)) begin
                        // Slave cycle cannot be aborted; just swallow its ack.
                        drop <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter; the timeout scenario is built only when
// MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;
    localparam int XLEN = 32;

    typedef struct packed {
        logic        w_en;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } req_t;

    typedef struct packed {
        req_t        req;
        logic        if_ack;
        logic        lsu_ack;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mem_arb_if #(.XLEN(XLEN)) bus ();

    mem_arbiter #(
        .XLEN           (XLEN),
        .MAX_LSU_STREAK (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1);
    end

    // Slave model: wait for a request, hold it lat cycles, ack once with rd.
    task automatic serve(input int lat, input logic [31:0] rd, input bit clr_if, input bit clr_lsu,
                         output bit got, output int waited, output req_t seen, output logic stable,
                         output logic if_ack, output logic lsu_ack, output logic [31:0] rdata,
                         output logic req_after, output logic ack_after);
        got = 0; waited = 0; seen = '0; stable = 1'b1;
        if_ack = 1'bx; lsu_ack = 1'bx; rdata = 'x; req_after = 1'bx; ack_after = 1'bx;
        for (int i = 0; i < 32 && !got; i++) begin
            @(negedge clk); #1;
            if (bus.mem_req_o) begin
                got  = 1;
                seen = {bus.mem_w_en_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_sel_o};
            end else waited++;
        end
        if (!got) return;
        repeat (lat) begin
            @(negedge clk); #1;
            if ({bus.mem_req_o, bus.mem_w_en_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_sel_o}
                !== {1'b1, seen}) stable = 1'b0;
        end
        @(negedge clk); bus.mem_ack_i = 1'b1; bus.mem_rdata_i = rd; #1;
        if ({bus.mem_req_o, bus.mem_w_en_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_sel_o}
            !== {1'b1, seen}) stable = 1'b0;
        if_ack  = bus.if_ack_o;
        lsu_ack = bus.lsu_ack_o;
        rdata   = bus.lsu_ack_o ? bus.lsu_rdata_o : bus.if_rdata_o;
        @(negedge clk); bus.mem_ack_i = 1'b0; bus.mem_rdata_i = '0;
        if (clr_if)  bus.if_req_i  = 1'b0;
        if (clr_lsu) bus.lsu_req_i = 1'b0;
        #1;
        req_after = bus.mem_req_o;
        ack_after = bus.if_ack_o | bus.lsu_ack_o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.if_req_i = 0; bus.if_addr_i = '0; bus.if_kill_i = 0;
        bus.lsu_req_i = 0; bus.lsu_addr_i = '0; bus.lsu_wdata_i = '0; bus.lsu_sel_i = '0;
        bus.lsu_w_en_i = 0; bus.lsu_flush_i = 0; bus.mem_ack_i = 0; bus.mem_rdata_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0; #1;
        chk_cnt++;
        if ({bus.mem_req_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_sel_o, bus.mem_w_en_o} !== '0)
            $display("FAIL reset_mem_outputs: got req=%b addr=%h wdata=%h sel=%h w_en=%b, need all 0",
                     bus.mem_req_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_sel_o, bus.mem_w_en_o);
        else pass_cnt++;
        chk_cnt++;
        if ({bus.if_ack_o, bus.lsu_ack_o, bus.mem_err_o} !== 3'b000)
            $display("FAIL reset_acks: got if_ack/lsu_ack/err=%b, need 000",
                     {bus.if_ack_o, bus.lsu_ack_o, bus.mem_err_o});
        else pass_cnt++;
    endtask

    task automatic test_fetch();
        bit got; int w; req_t s; exp_t e; logic st, ia, la, ra, aa; logic [31:0] rd;
        @(negedge clk); bus.if_req_i = 1; bus.if_addr_i = 32'h8000_0000;
        exp_q.push_back('{req: '{w_en: 0, addr: 32'h8000_0000, wdata: 0, sel: 4'hF},
                          if_ack: 1, lsu_ack: 0, rdata: 32'h13});
        serve(1, 32'h13, 1, 0, got, w, s, st, ia, la, rd, ra, aa);
        e = exp_q.pop_front();
        chk_cnt++;
        if (!got || w !== 0) $display("FAIL fetch_latency: got=%0d idle_cycles=%0d, need 1/0", got, w);
        else pass_cnt++;
        chk_cnt++;
        if ({s.w_en, s.addr, s.sel} !== {e.req.w_en, e.req.addr, e.req.sel} || st !== 1'b1)
            $display("FAIL fetch_request: got w_en=%b addr=%h sel=%h stable=%b, need %b %h %h 1",
                     s.w_en, s.addr, s.sel, st, e.req.w_en, e.req.addr, e.req.sel);
        else pass_cnt++;
        chk_cnt++;
        if ({ia, la, rd} !== {e.if_ack, e.lsu_ack, e.rdata})
            $display("FAIL fetch_ack: got if=%b lsu=%b rdata=%h, need %b %b %h",
                     ia, la, rd, e.if_ack, e.lsu_ack, e.rdata);
        else pass_cnt++;
        chk_cnt++;
        if ({ra, aa} !== 2'b00) $display("FAIL fetch_after_ack: got req=%b ack=%b, need 0 0", ra, aa);
        else pass_cnt++;
    endtask

    task automatic test_priority();
        bit got; int w; req_t s; exp_t e; logic st, ia, la, ra, aa; logic [31:0] rd;
        @(negedge clk);
        bus.if_req_i = 1; bus.if_addr_i = 32'h8000_0004;
        bus.lsu_req_i = 1; bus.lsu_addr_i = 32'h1000; bus.lsu_wdata_i = 32'hDEAD_BEEF;
        bus.lsu_sel_i = 4'hF; bus.lsu_w_en_i = 1;
        exp_q.push_back('{req: '{w_en: 1, addr: 32'h1000, wdata: 32'hDEAD_BEEF, sel: 4'hF},
                          if_ack: 0, lsu_ack: 1, rdata: 32'h0});
        exp_q.push_back('{req: '{w_en: 0, addr: 32'h8000_0004, wdata: 0, sel: 4'hF},
                          if_ack: 1, lsu_ack: 0, rdata: 32'h0000_0093});
        serve(1, 32'h0, 0, 1, got, w, s, st, ia, la, rd, ra, aa);
        e = exp_q.pop_front();
        chk_cnt++;
        if (!got || s !== e.req || {ia, la} !== {e.if_ack, e.lsu_ack})
            $display("FAIL prio_lsu_first: got req=%h if=%b lsu=%b, need %h %b %b",
                     s, ia, la, e.req, e.if_ack, e.lsu_ack);
        else pass_cnt++;
        chk_cnt++;
        if (ra !== 1'b0) $display("FAIL prio_bubble: got mem_req=%b in bubble, need 0", ra);
        else pass_cnt++;
        serve(0, 32'h0000_0093, 1, 0, got, w, s, st, ia, la, rd, ra, aa);
        e = exp_q.pop_front();
        chk_cnt++;
        if (!got || w !== 0 || {s.w_en, s.addr, s.sel} !== {e.req.w_en, e.req.addr, e.req.sel} ||
            {ia, la, rd} !== {e.if_ack, e.lsu_ack, e.rdata})
            $display("FAIL prio_if_second: got got=%0d wait=%0d addr=%h if=%b rdata=%h, need 1 0 %h %b %h",
                     got, w, s.addr, ia, rd, e.req.addr, e.if_ack, e.rdata);
        else pass_cnt++;
    endtask

    task automatic test_streak();
        bit got; int w; req_t s; exp_t e; logic st, ia, la, ra, aa; logic [31:0] rd;
        @(negedge clk);
        bus.if_req_i = 1; bus.if_addr_i = 32'h8000_0008;
        bus.lsu_req_i = 1; bus.lsu_addr_i = 32'h2000; bus.lsu_w_en_i = 0; bus.lsu_sel_i = 4'h3;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 5; k++) begin
                if (k < 4)
                    exp_q.push_back('{req: '{w_en: 0, addr: 32'h2000, wdata: 0, sel: 4'h3},
                                      if_ack: 0, lsu_ack: 1, rdata: 32'(k + 16 * r)});
                else
                    exp_q.push_back('{req: '{w_en: 0, addr: 32'h8000_0008, wdata: 0, sel: 4'hF},
                                      if_ack: 1, lsu_ack: 0, rdata: 32'(k + 16 * r)});
                serve(0, 32'(k + 16 * r), (r == 1 && k == 4), (r == 1 && k == 4),
                      got, w, s, st, ia, la, rd, ra, aa);
                e = exp_q.pop_front();
                chk_cnt++;
                if (!got || {s.addr, s.sel} !== {e.req.addr, e.req.sel} ||
                    {ia, la, rd} !== {e.if_ack, e.lsu_ack, e.rdata})
                    $display("FAIL streak_r%0d_g%0d: got addr=%h if=%b lsu=%b rdata=%h, need %h %b %b %h",
                             r, k, s.addr, ia, la, rd, e.req.addr, e.if_ack, e.lsu_ack, e.rdata);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_flush();
        bit got = 0; int w; req_t s; exp_t e; logic st, ia, la, ra, aa; logic [31:0] rd;
        logic lsu_seen = 0, if_seen = 0;
        @(negedge clk);
        bus.lsu_req_i = 1; bus.lsu_addr_i = 32'h3000; bus.lsu_w_en_i = 0; bus.lsu_sel_i = 4'hF;
        bus.if_req_i = 1; bus.if_addr_i = 32'h8000_0010;
        for (int i = 0; i < 32 && !got; i++) begin
            @(negedge clk); #1;
            if (bus.mem_req_o) got = 1;
        end
        chk_cnt++;
        if (!got || bus.mem_addr_o !== 32'h3000)
            $display("FAIL flush_grant: got req=%0d addr=%h, need 1 00003000", got, bus.mem_addr_o);
        else pass_cnt++;
        @(negedge clk); bus.lsu_flush_i = 1; bus.lsu_req_i = 0; #1;
        lsu_seen |= bus.lsu_ack_o;
        @(negedge clk); bus.lsu_flush_i = 0; #1;
        lsu_seen |= bus.lsu_ack_o;
        @(negedge clk); bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h55; #1;
        lsu_seen |= bus.lsu_ack_o; if_seen |= bus.if_ack_o;
        @(negedge clk); bus.mem_ack_i = 0; bus.mem_rdata_i = '0; #1;
        chk_cnt++;
        if ({lsu_seen, if_seen, bus.mem_req_o} !== 3'b000)
            $display("FAIL flush_suppress: got lsu_ack=%b if_ack=%b mem_req=%b, need 0 0 0",
                     lsu_seen, if_seen, bus.mem_req_o);
        else pass_cnt++;
        exp_q.push_back('{req: '{w_en: 0, addr: 32'h8000_0010, wdata: 0, sel: 4'hF},
                          if_ack: 1, lsu_ack: 0, rdata: 32'h0010_0073});
        serve(0, 32'h0010_0073, 1, 0, got, w, s, st, ia, la, rd, ra, aa);
        e = exp_q.pop_front();
        chk_cnt++;
        if (!got || w !== 0 || s.addr !== e.req.addr || {ia, la, rd} !== {e.if_ack, e.lsu_ack, e.rdata})
            $display("FAIL flush_then_if: got wait=%0d addr=%h if=%b rdata=%h, need 0 %h %b %h",
                     w, s.addr, ia, rd, e.req.addr, e.if_ack, e.rdata);
        else pass_cnt++;
    endtask

    task automatic test_idle_withdraw();
        bit got; int w; req_t s; exp_t e; logic st, ia, la, ra, aa; logic [31:0] rd;
        logic any_req = 0;
        @(negedge clk);
        bus.if_req_i = 1; bus.if_kill_i = 1; bus.if_addr_i = 32'h8000_0040;
        bus.lsu_req_i = 1; bus.lsu_flush_i = 1; bus.lsu_addr_i = 32'h5000;
        repeat (3) begin
            @(negedge clk); #1;
            any_req |= bus.mem_req_o;
        end
        chk_cnt++;
        if (any_req !== 1'b0) $display("FAIL idle_withdraw: got mem_req=%b, need 0", any_req);
        else pass_cnt++;
        bus.if_kill_i = 0; bus.lsu_req_i = 0; bus.lsu_flush_i = 0;
        exp_q.push_back('{req: '{w_en: 0, addr: 32'h8000_0040, wdata: 0, sel: 4'hF},
                          if_ack: 1, lsu_ack: 0, rdata: 32'hA5A5_0001});
        serve(0, 32'hA5A5_0001, 1, 0, got, w, s, st, ia, la, rd, ra, aa);
        e = exp_q.pop_front();
        chk_cnt++;
        if (!got || w !== 0 || s.addr !== e.req.addr || {ia, la, rd} !== {e.if_ack, e.lsu_ack, e.rdata})
            $display("FAIL withdraw_release: got wait=%0d addr=%h if=%b rdata=%h, need 0 %h %b %h",
                     w, s.addr, ia, rd, e.req.addr, e.if_ack, e.rdata);
        else pass_cnt++;
    endtask

    task automatic test_reset_busy();
        bit got = 0;
        @(negedge clk); bus.if_req_i = 1; bus.if_addr_i = 32'h8000_0020;
        for (int i = 0; i < 32 && !got; i++) begin
            @(negedge clk); #1;
            if (bus.mem_req_o) got = 1;
        end
        chk_cnt++;
        if (!got) $display("FAIL rstbusy_grant: got no request, need mem_req=1");
        else pass_cnt++;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0; bus.if_req_i = 0; #1;
        chk_cnt++;
        if ({bus.mem_req_o, bus.if_ack_o, bus.lsu_ack_o} !== 3'b000)
            $display("FAIL rstbusy_abandon: got req/if_ack/lsu_ack=%b, need 000",
                     {bus.mem_req_o, bus.if_ack_o, bus.lsu_ack_o});
        else pass_cnt++;
        @(negedge clk); bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h1234_5678; #1;
        chk_cnt++;
        if ({bus.if_ack_o, bus.lsu_ack_o} !== 2'b00)
            $display("FAIL rstbusy_late_ack: got if=%b lsu=%b, need 0 0", bus.if_ack_o, bus.lsu_ack_o);
        else pass_cnt++;
        @(negedge clk); bus.mem_ack_i = 0; bus.mem_rdata_i = '0;
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bit got = 0; int c = 0; logic err = 0, la = 0; logic [31:0] lrd = 'x;
        @(negedge clk);
        bus.lsu_req_i = 1; bus.lsu_addr_i = 32'h4000; bus.lsu_w_en_i = 0;
        bus.mem_rdata_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 32 && !got; i++) begin
            @(negedge clk); #1;
            if (bus.mem_req_o) begin
                got = 1; c = 1; err = bus.mem_err_o; la = bus.lsu_ack_o; lrd = bus.lsu_rdata_o;
            end
        end
        while (got && !err && c < 20) begin
            @(negedge clk); #1;
            c++; err = bus.mem_err_o; la = bus.lsu_ack_o; lrd = bus.lsu_rdata_o;
        end
        chk_cnt++;
        if (!err || c !== 8 || la !== 1'b1 || lrd !== 32'h0)
            $display("FAIL timeout_pulse: got err=%b cycle=%0d lsu_ack=%b rdata=%h, need 1 8 1 0",
                     err, c, la, lrd);
        else pass_cnt++;
        @(negedge clk); bus.lsu_req_i = 0; bus.mem_rdata_i = '0; #1;
        chk_cnt++;
        if ({bus.mem_req_o, bus.mem_err_o} !== 2'b00)
            $display("FAIL timeout_idle: got req=%b err=%b, need 0 0", bus.mem_req_o, bus.mem_err_o);
        else pass_cnt++;
        @(negedge clk); bus.mem_ack_i = 1; #1;
        chk_cnt++;
        if (bus.lsu_ack_o !== 1'b0) $display("FAIL timeout_late_ack: got lsu_ack=%b, need 0", bus.lsu_ack_o);
        else pass_cnt++;
        @(negedge clk); bus.mem_ack_i = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_streak();
        test_flush();
        test_idle_withdraw();
        test_reset_busy();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        if (exp_q.size() != 0) begin
            chk_cnt++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, need 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
